// File: rtl/core_pkg.sv
// Core-wide shared definitions: datapath widths plus the memory-port
// identifiers used by mem_arbiter and its route queue.
package core_pkg;

    localparam int unsigned Xlen     = 64;
    localparam int unsigned MaskBits = 8;

    // Identity of a memory requester; stored per outstanding request.
    typedef enum logic {
        MemPortIf = 1'b0,
        MemPortLs = 1'b1
    } mem_port_e;

    // Downstream handshake lock: Held pins the grant while a request waits for ready.
    typedef enum logic {
        LockFree = 1'b0,
        LockHeld = 1'b1
    } mem_lock_e;

endpackage

// File: rtl/mem_arb_route_fifo.sv
// In-order route queue for mem_arbiter: remembers which requester owns each
// accepted-but-unanswered memory request. Supports push and pop in the same
// cycle; a pop on an empty queue and a push on a full queue are ignored.
module mem_arb_route_fifo
    import core_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      push_i,
    input  mem_port_e push_id_i,
    input  logic      pop_i,
    output logic      full_o,
    output logic      empty_o,
    output mem_port_e head_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth) + 1;

    mem_port_e       entries_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            push_en;
    logic            pop_en;

    // Wrap at Depth-1; identical to natural wrap for power-of-two depths.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        if (ptr == PtrW'(Depth - 1)) begin
            return '0;
        end
        return ptr + 1'b1;
    endfunction

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign head_o  = entries_q[rd_ptr_q];
    assign push_en = push_i & ~full_o;
    assign pop_en  = pop_i & ~empty_o;

    // Next pointer and occupancy values; simultaneous push/pop keeps the count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop_en) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Queue control state, cleared asynchronously so reset empties the queue.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk_i) begin
        if (push_en) begin
            entries_q[wr_ptr_q] <= push_id_i;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory port arbiter: instruction fetch (port 0) and the
// load/store unit (port 1) share one downstream valid/ready request port.
// Request and response paths are combinational; an in-order route queue
// steers each response beat back to the requester that issued it.
// Optional build macro MEM_ARB_RR_EN: round-robin arbitration instead of the
// default fixed LSU-over-fetch priority.
module mem_arbiter #(
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned Xlen           = core_pkg::Xlen,
    parameter int unsigned MaskBits       = core_pkg::MaskBits
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                if_valid_i,
    output logic                if_ready_o,
    input  logic [Xlen-1:0]     if_addr_i,
    output logic [Xlen-1:0]     if_rdata_o,
    output logic                if_rvalid_o,
    input  logic                ls_valid_i,
    output logic                ls_ready_o,
    input  logic [Xlen-1:0]     ls_addr_i,
    input  logic [Xlen-1:0]     ls_wdata_i,
    input  logic [MaskBits-1:0] ls_wmask_i,
    output logic [Xlen-1:0]     ls_rdata_o,
    output logic                ls_rvalid_o,
    output logic                mem_valid_o,
    input  logic                mem_ready_i,
    output logic [Xlen-1:0]     mem_addr_o,
    output logic [Xlen-1:0]     mem_wdata_o,
    output logic [MaskBits-1:0] mem_wmask_o,
    input  logic [Xlen-1:0]     mem_rdata_i,
    input  logic                mem_rvalid_i
);

    import core_pkg::*;

    logic      route_full;
    logic      route_empty;
    mem_port_e route_head;
    mem_port_e grant;
    logic      accept;
    mem_lock_e lock_q, lock_d;
    mem_port_e lock_id_q, lock_id_d;
`ifdef MEM_ARB_RR_EN
    mem_port_e rr_q, rr_d;
`endif

    // Grant selection: a held lock wins, otherwise the arbitration policy.
    always_comb begin
        grant = MemPortIf;
        if (lock_q == LockHeld) begin
            grant = lock_id_q;
`ifdef MEM_ARB_RR_EN
        end else if (ls_valid_i && if_valid_i) begin
            // rr_q names the previous winner, which loses the tie.
            grant = (rr_q == MemPortLs) ? MemPortIf : MemPortLs;
`endif
        end else if (ls_valid_i) begin
            grant = MemPortLs;
        end else begin
            grant = MemPortIf;
        end
    end

    assign mem_valid_o = (if_valid_i | ls_valid_i) & ~route_full;
    assign accept      = mem_valid_o & mem_ready_i;
    assign if_ready_o  = accept & (grant == MemPortIf);
    assign ls_ready_o  = accept & (grant == MemPortLs);

    // Downstream payload mux; fetches never write.
    always_comb begin
        mem_addr_o  = if_addr_i;
        mem_wdata_o = '0;
        mem_wmask_o = '0;
        if (grant == MemPortLs) begin
            mem_addr_o  = ls_addr_i;
            mem_wdata_o = ls_wdata_i;
            mem_wmask_o = ls_wmask_i;
        end
    end

    // Lock next-state: pin the grant while the downstream stalls a valid request.
    always_comb begin
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        case (lock_q)
            LockFree: begin
                if (mem_valid_o && !mem_ready_i) begin
                    lock_d    = LockHeld;
                    lock_id_d = grant;
                end
            end
            LockHeld: begin
                if (accept) begin
                    lock_d = LockFree;
                end
            end
        endcase
    end

`ifdef MEM_ARB_RR_EN
    // Round-robin history: remember the most recently accepted port.
    always_comb begin
        rr_d = accept ? grant : rr_q;
    end
`endif

    // Lock state machine and arbitration history registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q    <= LockFree;
            lock_id_q <= MemPortIf;
`ifdef MEM_ARB_RR_EN
            rr_q      <= MemPortIf;
`endif
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
`ifdef MEM_ARB_RR_EN
            rr_q      <= rr_d;
`endif
        end
    end

    // Response steering: data is broadcast, only the queue head's owner sees rvalid.
    // A response with nothing outstanding is dropped (no rvalid, queue untouched).
    assign if_rdata_o  = mem_rdata_i;
    assign ls_rdata_o  = mem_rdata_i;
    assign if_rvalid_o = mem_rvalid_i & ~route_empty & (route_head == MemPortIf);
    assign ls_rvalid_o = mem_rvalid_i & ~route_empty & (route_head == MemPortLs);

    mem_arb_route_fifo #(
        .Depth(MaxOutstanding)
    ) u_route_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push_i   (accept),
        .push_id_i(grant),
        .pop_i    (mem_rvalid_i),
        .full_o   (route_full),
        .empty_o  (route_empty),
        .head_o   (route_head)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written
// reset and arbitration-order sequences, then randomized traffic against a
// queue-based reference model of the routing rules.
module tb_mem_arbiter;

    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid, if_ready, if_rvalid;
    logic [63:0] if_addr, if_rdata;
    logic        ls_valid, ls_ready, ls_rvalid;
    logic [63:0] ls_addr, ls_wdata, ls_rdata;
    logic [7:0]  ls_wmask;
    logic        mem_valid, mem_ready, mem_rvalid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MaxOutstanding(MAXO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .if_valid_i(if_valid), .if_ready_o(if_ready), .if_addr_i(if_addr),
        .if_rdata_o(if_rdata), .if_rvalid_o(if_rvalid),
        .ls_valid_i(ls_valid), .ls_ready_o(ls_ready), .ls_addr_i(ls_addr),
        .ls_wdata_i(ls_wdata), .ls_wmask_i(ls_wmask), .ls_rdata_o(ls_rdata),
        .ls_rvalid_o(ls_rvalid),
        .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_wmask_o(mem_wmask), .mem_rdata_i(mem_rdata),
        .mem_rvalid_i(mem_rvalid)
    );

    // A stalled downstream request must stay valid with an unchanged address.
    a_lock_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (mem_valid && !mem_ready) |=> (mem_valid && $stable(mem_addr)))
        else begin
            n_err++;
            $display("FAIL lock_stable: mem_valid_o=%b mem_addr_o=%h, required valid with held address",
                     mem_valid, mem_addr);
        end

    typedef struct {
        logic        ifv;  logic [63:0] ifa;
        logic        lsv;  logic [63:0] lsa; logic [63:0] lsd; logic [7:0] lsm;
        logic        rdy;  logic        rv;  logic [63:0] rd;
        logic        e_mv; logic [63:0] e_addr; logic [63:0] e_wd; logic [7:0] e_wm;
        logic        e_ifr; logic e_lsr; logic e_ifrv; logic e_lsrv;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(
        input logic ifv, input logic [63:0] ifa,
        input logic lsv, input logic [63:0] lsa, input logic [63:0] lsd, input logic [7:0] lsm,
        input logic rdy, input logic rv, input logic [63:0] rd,
        input logic e_mv, input logic [63:0] e_addr, input logic [63:0] e_wd, input logic [7:0] e_wm,
        input logic e_ifr, input logic e_lsr, input logic e_ifrv, input logic e_lsrv);
        vec_t v;
        v.ifv = ifv; v.ifa = ifa; v.lsv = lsv; v.lsa = lsa; v.lsd = lsd; v.lsm = lsm;
        v.rdy = rdy; v.rv = rv; v.rd = rd;
        v.e_mv = e_mv; v.e_addr = e_addr; v.e_wd = e_wd; v.e_wm = e_wm;
        v.e_ifr = e_ifr; v.e_lsr = e_lsr; v.e_ifrv = e_ifrv; v.e_lsrv = e_lsrv;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ifv, input logic [63:0] ifa, input logic lsv,
                         input logic [63:0] lsa, input logic [63:0] lsd, input logic [7:0] lsm,
                         input logic rdy, input logic rv, input logic [63:0] rd);
        if_valid = ifv; if_addr = ifa;
        ls_valid = lsv; ls_addr = lsa; ls_wdata = lsd; ls_wmask = lsm;
        mem_ready = rdy; mem_rvalid = rv; mem_rdata = rd;
    endtask

    // Apply one vector at a falling edge, check the combinational outputs, advance a cycle.
    task automatic apply_vec(input vec_t v, input string tag);
        drive(v.ifv, v.ifa, v.lsv, v.lsa, v.lsd, v.lsm, v.rdy, v.rv, v.rd);
        #2;
        chk({tag, ".mem_valid"}, 64'(mem_valid), 64'(v.e_mv));
        chk({tag, ".if_ready"},  64'(if_ready),  64'(v.e_ifr));
        chk({tag, ".ls_ready"},  64'(ls_ready),  64'(v.e_lsr));
        chk({tag, ".if_rvalid"}, 64'(if_rvalid), 64'(v.e_ifrv));
        chk({tag, ".ls_rvalid"}, 64'(ls_rvalid), 64'(v.e_lsrv));
        if (v.e_mv) begin
            chk({tag, ".mem_addr"},  mem_addr,         v.e_addr);
            chk({tag, ".mem_wdata"}, mem_wdata,        v.e_wd);
            chk({tag, ".mem_wmask"}, 64'(mem_wmask),   64'(v.e_wm));
        end
        if (v.e_ifrv || v.e_lsrv) begin
            chk({tag, ".if_rdata"}, if_rdata, v.rd);
            chk({tag, ".ls_rdata"}, ls_rdata, v.rd);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Reference model state: owners of outstanding requests, pinned grant, last winner.
    int          mq[$];
    int          held;
    int          last_win;
    logic        if_pend, ls_pend;
    logic [63:0] r_ifa, r_lsa, r_lsd;
    logic [7:0]  r_lsm;

    initial begin
        vec_t v;
        bit   rr_build;
`ifdef MEM_ARB_RR_EN
        rr_build = 1'b1;
`else
        rr_build = 1'b0;
`endif
        //            ifv ifa       lsv lsa       lsd    lsm    rdy rv rd        mv addr      wd     wm     ifr lsr ifrv lsrv
        tbl[0]  = mk(0, 0,        0, 0,        0,     0,     1, 0, 0,        0, 0,        0,     0,     0, 0, 0, 0);
        tbl[1]  = mk(1, 64'h1000, 0, 0,        0,     0,     1, 0, 0,        1, 64'h1000, 0,     0,     1, 0, 0, 0);
        tbl[2]  = mk(0, 0,        0, 0,        0,     0,     1, 0, 0,        0, 0,        0,     0,     0, 0, 0, 0);
        tbl[3]  = mk(0, 0,        0, 0,        0,     0,     1, 1, 64'hDEAD, 0, 0,        0,     0,     0, 0, 1, 0);
        tbl[4]  = mk(1, 64'h1100, 1, 64'h2000, 64'h55, 8'h0F, 1, 0, 0,       1, 64'h2000, 64'h55, 8'h0F, 0, 1, 0, 0);
        tbl[5]  = mk(1, 64'h1100, 0, 0,        0,     0,     1, 0, 0,        1, 64'h1100, 0,     0,     1, 0, 0, 0);
        tbl[6]  = mk(0, 0,        0, 0,        0,     0,     1, 1, 64'h11,   0, 0,        0,     0,     0, 0, 0, 1);
        tbl[7]  = mk(0, 0,        0, 0,        0,     0,     1, 1, 64'h22,   0, 0,        0,     0,     0, 0, 1, 0);
        tbl[8]  = mk(1, 64'h3000, 0, 0,        0,     0,     0, 0, 0,        1, 64'h3000, 0,     0,     0, 0, 0, 0);
        tbl[9]  = mk(1, 64'h3000, 0, 0,        0,     0,     0, 0, 0,        1, 64'h3000, 0,     0,     0, 0, 0, 0);
        tbl[10] = mk(1, 64'h3000, 1, 64'h4000, 64'h77, 0,    0, 0, 0,        1, 64'h3000, 0,     0,     0, 0, 0, 0);
        tbl[11] = mk(1, 64'h3000, 1, 64'h4000, 64'h77, 0,    1, 0, 0,        1, 64'h3000, 0,     0,     1, 0, 0, 0);
        tbl[12] = mk(0, 0,        1, 64'h4000, 64'h77, 0,    1, 0, 0,        1, 64'h4000, 64'h77, 0,    0, 1, 0, 0);
        tbl[13] = mk(1, 64'h5000, 0, 0,        0,     0,     1, 0, 0,        0, 0,        0,     0,     0, 0, 0, 0);
        tbl[14] = mk(1, 64'h5000, 0, 0,        0,     0,     1, 1, 64'h33,   0, 0,        0,     0,     0, 0, 1, 0);
        tbl[15] = mk(1, 64'h5000, 0, 0,        0,     0,     1, 1, 64'h44,   1, 64'h5000, 0,     0,     1, 0, 0, 1);
        tbl[16] = mk(0, 0,        0, 0,        0,     0,     1, 1, 64'h55,   0, 0,        0,     0,     0, 0, 1, 0);

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #2;
        chk("reset.mem_valid", 64'(mem_valid), 0);
        chk("reset.readies",   64'({if_ready, ls_ready}), 0);
        chk("reset.rvalids",   64'({if_rvalid, ls_rvalid}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            apply_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of traffic with two requests outstanding.
        apply_vec(mk(1, 64'h6000, 0, 0, 0, 0, 1, 0, 0, 1, 64'h6000, 0, 0, 1, 0, 0, 0), "rst.fill0");
        apply_vec(mk(1, 64'h6008, 0, 0, 0, 0, 1, 0, 0, 1, 64'h6008, 0, 0, 1, 0, 0, 0), "rst.fill1");
        apply_vec(mk(1, 64'h6010, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst.full");
        drive(0, 0, 0, 0, 0, 0, 0, 1, 64'hBAD);
        rst_n = 1'b0;
        #2;
        chk("rst.during.mem_valid", 64'(mem_valid), 0);
        chk("rst.during.rvalids",   64'({if_rvalid, ls_rvalid}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        apply_vec(mk(0, 0, 0, 0, 0, 0, 1, 1, 64'hBAD, 0, 0, 0, 0, 0, 0, 0, 0), "rst.stray_rvalid");
        apply_vec(mk(1, 64'h6020, 0, 0, 0, 0, 1, 0, 0, 1, 64'h6020, 0, 0, 1, 0, 0, 0), "rst.post0");
        apply_vec(mk(1, 64'h6028, 0, 0, 0, 0, 1, 0, 0, 1, 64'h6028, 0, 0, 1, 0, 0, 0), "rst.post1");
        apply_vec(mk(0, 0, 0, 0, 0, 0, 1, 1, 64'hA1, 0, 0, 0, 0, 0, 0, 1, 0), "rst.resp0");
        apply_vec(mk(0, 0, 0, 0, 0, 0, 1, 1, 64'hA2, 0, 0, 0, 0, 0, 0, 1, 0), "rst.resp1");

        // Both ports valid continuously: round-robin alternates, fixed priority keeps LSU.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            logic exp_ls;
            drive(1, 64'h7100, 1, 64'h7000, 64'h99, 8'hF0, 1, (i > 0), 64'h0);
            #2;
            exp_ls = rr_build ? ((i % 2) == 0) : 1'b1;
            chk($sformatf("order%0d.ls_ready", i), 64'(ls_ready), 64'(exp_ls));
            chk($sformatf("order%0d.if_ready", i), 64'(if_ready), 64'(!exp_ls));
            @(negedge clk);
        end

        // Randomized traffic against the reference model.
        do_reset();
        mq.delete();
        held = -1; last_win = 0;
        if_pend = 0; ls_pend = 0;
        r_ifa = 0; r_lsa = 0; r_lsd = 0; r_lsm = 0;
        for (int c = 0; c < 3000; c++) begin
            logic        rdy, rv, e_mv, acc, e_ifrv, e_lsrv;
            logic [63:0] rd;
            int          g;
            if (!if_pend && $urandom_range(0, 1) == 1) begin
                if_pend = 1; r_ifa = {$urandom, $urandom};
            end
            if (!ls_pend && $urandom_range(0, 1) == 1) begin
                ls_pend = 1; r_lsa = {$urandom, $urandom}; r_lsd = {$urandom, $urandom};
                r_lsm = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
            end
            rdy = ($urandom_range(0, 3) != 0);
            rv  = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
            rd  = {$urandom, $urandom};
            drive(if_pend, r_ifa, ls_pend, r_lsa, r_lsd, r_lsm, rdy, rv, rd);

            e_mv = (if_pend || ls_pend) && (mq.size() < MAXO);
            if (held >= 0)               g = held;
            else if (if_pend && ls_pend) g = rr_build ? ((last_win == 1) ? 0 : 1) : 1;
            else                         g = ls_pend ? 1 : 0;
            acc    = e_mv && rdy;
            e_ifrv = rv && (mq.size() > 0) && (mq[0] == 0);
            e_lsrv = rv && (mq.size() > 0) && (mq[0] == 1);

            #2;
            chk("rand.mem_valid", 64'(mem_valid), 64'(e_mv));
            chk("rand.if_ready",  64'(if_ready),  64'(acc && g == 0));
            chk("rand.ls_ready",  64'(ls_ready),  64'(acc && g == 1));
            chk("rand.if_rvalid", 64'(if_rvalid), 64'(e_ifrv));
            chk("rand.ls_rvalid", 64'(ls_rvalid), 64'(e_lsrv));
            if (e_mv) begin
                chk("rand.mem_addr",  mem_addr,       (g == 1) ? r_lsa : r_ifa);
                chk("rand.mem_wdata", mem_wdata,      (g == 1) ? r_lsd : 64'h0);
                chk("rand.mem_wmask", 64'(mem_wmask), (g == 1) ? 64'(r_lsm) : 64'h0);
            end
            if (rv) begin
                chk("rand.if_rdata", if_rdata, rd);
                chk("rand.ls_rdata", ls_rdata, rd);
            end

            if (rv && mq.size() > 0) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(g);
                last_win = g;
                held = -1;
                if (g == 1) ls_pend = 0; else if_pend = 0;
            end else if (e_mv && !rdy && held < 0) begin
                held = g;
            end
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
